// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage.
// States, instruction size and PC alignment mask.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register.
// load (redirect, word-aligned) wins over en (step by one instruction).
module pc_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  output logic [ADDR_W-1:0] q
);

  // redirect or sequential advance; the add wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= load_val & PC_ALIGN_MASK[ADDR_W-1:0];
    end else if (en) begin
      q <= q + ADDR_W'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC ownership, imem handshake, IF/ID register.
// Optional perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects
`endif
);

  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] hold_q;
  logic load, use_buf, cap;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (branch_taken),
    .load_val(branch_target),
    .en      (load),
    .q       (pc_q)
  );

  // A request squashed by a same-cycle redirect is never issued,
  // so no stale response can reach the redirected fetch.
  assign imem_req  = (state_q == REQ) && !branch_taken;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state and load/capture strobes; redirect overrides all
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    use_buf = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (stall) begin
            cap     = 1'b1;
            state_d = HOLD;
          end else begin
            load    = 1'b1;
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          load    = 1'b1;
          use_buf = 1'b1;
          state_d = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (branch_taken) begin
      load    = 1'b0;
      use_buf = 1'b0;
      cap     = 1'b0;
      if ((state_q == WAIT || state_q == DROP) && !imem_rvalid)
        state_d = DROP;
      else
        state_d = REQ;
    end
  end

  // word returned while stalled waits here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  hold_q <= '0;
    else if (cap)  hold_q <= imem_rdata;
  end

  // IF/ID register: load, hold on stall, bubble otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else if (branch_taken) begin
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_valid <= !flush;
      if_id_pc    <= pc_q;
      if_id_instr <= use_buf ? hold_q : imem_rdata;
    end else if (stall) begin
      if (flush) if_id_valid <= 1'b0;
    end else begin
      if_id_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // saturating fetch and redirect counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (load && perf_fetched != 32'hFFFF_FFFF)
        perf_fetched <= perf_fetched + 32'd1;
      if (branch_taken && perf_redirects != 32'hFFFF_FFFF)
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_rvalid_ctx: assert property (
    @(posedge clk) disable iff (!reset_n)
    imem_rvalid |-> (state_q == WAIT || state_q == DROP)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// checked against a transaction-level fetch model.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        branch_taken, stall, flush;
  logic [63:0] branch_target;
  logic        imem_req, imem_rvalid;
  logic [63:0] imem_addr, pc_out, if_id_pc;
  logic [31:0] imem_rdata, if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_redirects;
`endif

  fetch_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .flush        (flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_redirects(perf_redirects)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: fetch PC, IF/ID contents, request bookkeeping
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_ins, m_hins;
  bit m_vld, m_idle, m_req, m_out, m_sq, m_held;
  int unsigned m_fet, m_red;

  // memory responder
  bit pend;
  int pend_cnt;
  logic [31:0] pend_data;
  int lat_cfg;
  bit force_en;
  logic [31:0] force_data;
  logic [63:0] req_log[$];
  logic [63:0] vld_log[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_ipc = 64'h0; m_ins = 32'h0; m_hins = 32'h0;
    m_vld = 0; m_idle = 1; m_req = 0; m_out = 0; m_sq = 0; m_held = 0;
    m_fet = 0; m_red = 0;
    pend = 0; pend_cnt = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_pc", pc_out, 64'h0);
    check("rst_req", imem_req, 1'b0);
    check("rst_vld", if_id_valid, 1'b0);
    check("rst_ifpc", if_id_pc, 64'h0);
    check("rst_ins", if_id_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_pfet", perf_fetched, 32'h0);
    check("rst_pred", perf_redirects, 32'h0);
`endif
  endtask

  task automatic quiet();
    branch_taken = 0; stall = 0; flush = 0; imem_rvalid = 0;
    #1;
  endtask

  // one clock: drive, compare, feed memory, advance model
  task automatic step(input bit br, input logic [63:0] tgt,
                      input bit st, input bit fl);
    bit rv;
    bit dlv;
    logic [31:0] rd;
    logic [31:0] w;
    rv = 0;
    dlv = 0;
    w = 32'h0;
    rd = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rv = 1; rd = pend_data; pend = 0;
      end
    end
    branch_taken = br; branch_target = tgt;
    stall = st; flush = fl;
    imem_rvalid = rv; imem_rdata = rd;
    #1;
    check("imem_req", imem_req, m_req && !br);
    if (m_req && !br) check("imem_addr", imem_addr, m_pc);
    check("pc_out", pc_out, m_pc);
    check("if_id_valid", if_id_valid, m_vld);
    if (m_vld) begin
      check("if_id_pc", if_id_pc, m_ipc);
      check("if_id_instr", if_id_instr, m_ins);
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fet);
    check("perf_redirects", perf_redirects, m_red);
`endif
    if (imem_req) begin
      req_log.push_back(imem_addr);
      pend = 1;
      pend_cnt = (lat_cfg != 0) ? lat_cfg : $urandom_range(1, 3);
      pend_data = force_en ? force_data : $urandom;
      force_en = 0;
    end
    if (if_id_valid) vld_log.push_back(if_id_pc);
    if (br) begin
      m_red++;
      m_pc = {tgt[63:2], 2'b00};
      m_vld = 0;
      m_idle = 0;
      if (m_out && !rv) begin
        m_sq = 1;
      end else begin
        m_out = 0; m_held = 0; m_req = 1;
      end
    end else begin
      if (m_idle) begin
        m_idle = 0; m_req = 1;
      end else if (m_req) begin
        m_req = 0; m_out = 1; m_sq = 0;
      end else if (m_out && rv) begin
        m_out = 0;
        if (m_sq) m_req = 1;
        else if (!st) begin dlv = 1; w = rd; end
        else begin m_held = 1; m_hins = rd; end
      end else if (m_held && !st) begin
        m_held = 0; dlv = 1; w = m_hins;
      end
      if (dlv) begin
        m_fet++;
        m_ipc = m_pc; m_ins = w; m_vld = !fl;
        m_pc = m_pc + 64'd4;
        m_req = 1;
      end else if (st) begin
        m_vld = m_vld && !fl;
      end else begin
        m_vld = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_req();
    for (int n = 0; n < 10 && !m_req; n++) step(0, 64'h0, 0, 0);
  endtask

  initial begin
    logic [31:0] sv_ins;
    logic [63:0] sv_pc;
    bit sv_v;
    bit rb, rs, rf;
    logic [63:0] rt;

    reset_n = 1'b1;
    branch_taken = 0; branch_target = '0; stall = 0; flush = 0;
    imem_rvalid = 0; imem_rdata = '0;
    lat_cfg = 1; force_en = 0; force_data = '0;
    model_reset();
    #1 reset_n = 1'b0;
    #11;
    check_reset_vals();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // three back-to-back fetches at latency 1
    for (int i = 0; i < 8; i++) step(0, 64'h0, 0, 0);
    check("n_req", req_log.size() >= 3, 1'b1);
    check("n_vld", vld_log.size() >= 3, 1'b1);
    if (req_log.size() >= 3 && vld_log.size() >= 3) begin
      check("addr0", req_log[0], 64'h0);
      check("addr1", req_log[1], 64'h4);
      check("addr2", req_log[2], 64'h8);
      check("ifpc0", vld_log[0], 64'h0);
      check("ifpc1", vld_log[1], 64'h4);
      check("ifpc2", vld_log[2], 64'h8);
    end

    // stalled return goes to the hold buffer
    run_to_req();
    force_en = 1; force_data = 32'hDEAD_BEEF;
    step(0, 64'h0, 0, 0);
    sv_ins = if_id_instr; sv_v = if_id_valid; sv_pc = pc_out;
    step(0, 64'h0, 1, 0);
    step(0, 64'h0, 1, 0);
    check("stall_ins", if_id_instr, sv_ins);
    check("stall_vld", if_id_valid, sv_v);
    step(0, 64'h0, 0, 0);
    check("hold_ins", if_id_instr, 32'hDEAD_BEEF);
    check("hold_vld", if_id_valid, 1'b1);
    check("hold_ifpc", if_id_pc, sv_pc);
    check("hold_pc4", pc_out, sv_pc + 64'd4);

    // redirect while waiting: response dropped
    run_to_req();
    lat_cfg = 2;
    step(0, 64'h0, 0, 0);
    step(1, 64'h1000, 0, 0);
    step(0, 64'h0, 0, 0);
    quiet();
    check("drop_req", imem_req, 1'b1);
    check("drop_addr", imem_addr, 64'h1000);
    check("drop_vld", if_id_valid, 1'b0);
    lat_cfg = 1;

    // redirect beats stall, target realigned
    run_to_req();
    step(0, 64'h0, 0, 0);
    step(0, 64'h0, 1, 0);
    step(1, 64'h2003, 1, 0);
    quiet();
    check("bs_pc", pc_out, 64'h2000);
    check("bs_vld", if_id_valid, 1'b0);
    check("bs_req", imem_req, 1'b1);

    // PC wrap then flush
    run_to_req();
    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    step(0, 64'h0, 0, 0);
    step(0, 64'h0, 0, 0);
    quiet();
    check("wrap_pc", pc_out, 64'h0);
    check("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 64'h0);
    check("wrap_ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 64'h0, 0, 1);
    check("flush_vld", if_id_valid, 1'b0);
    check("flush_pc", pc_out, 64'h0);

    // reset during an outstanding read
    run_to_req();
    lat_cfg = 3;
    step(0, 64'h0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    lat_cfg = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rb = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 3) == 0);
      rf = ($urandom_range(0, 7) == 0);
      rt = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rt[63:16] = '0;
      step(rb, rt, rs, rf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
